// File: rtl/alu_seq_pkg.sv
// ---------------------------------------------------------------------------
// Package: alu_seq_pkg
// Purpose: Shared types and constants for the ALU accumulator sequencer.
//          Holds the command opcode enum, the sequencer FSM state enum, the
//          datapath width and a helper that maps a command opcode onto the
//          ALU function select.
// Contents:
//   DATA_W   - operand / accumulator width (fixed at 8 to match the ALU)
//   op_e     - command opcodes OP_ADD..OP_ILL
//   state_e  - sequencer states IDLE / EXEC / RESP
//   alu_sel  - opcode -> ALU X select (only 0..4 ever produced)
// ---------------------------------------------------------------------------
package alu_seq_pkg;

    localparam int DATA_W = 8;

    typedef enum logic [2:0] {
        OP_ADD   = 3'd0,
        OP_SUB   = 3'd1,
        OP_AND   = 3'd2,
        OP_OR    = 3'd3,
        OP_NOT   = 3'd4,
        OP_LOAD  = 3'd5,
        OP_CLEAR = 3'd6,
        OP_ILL   = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    // The ALU output is undefined for selects 5..7, so anything that is not
    // a real ALU operation parks the select at 0 (ADD).
    function automatic logic [2:0] alu_sel(input op_e op);
        return (op <= OP_NOT) ? 3'(op) : 3'd0;
    endfunction

endpackage

// File: rtl/alu_seq_flags.sv
// ---------------------------------------------------------------------------
// Module: alu_seq_flags
// Purpose: Combinational flag generation for the sequencer result.
//          Z is computed from the value about to become the result; with
//          ALU_SEQ_OVF_EN defined, V is the signed overflow of ADD/SUB.
// Configuration macro: ALU_SEQ_OVF_EN (adds a/b/op inputs and the v output)
// Ports:
//   s   in  DATA_W  next result value (new accumulator)
//   z   out 1       1 when s == 0
//   a   in  DATA_W  accumulator before the op        (ALU_SEQ_OVF_EN only)
//   b   in  DATA_W  registered operand B             (ALU_SEQ_OVF_EN only)
//   op  in  3       registered opcode                (ALU_SEQ_OVF_EN only)
//   v   out 1       signed overflow for ADD/SUB      (ALU_SEQ_OVF_EN only)
// ---------------------------------------------------------------------------
module alu_seq_flags
    import alu_seq_pkg::*;
(
`ifdef ALU_SEQ_OVF_EN
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [2:0]        op,
    output logic              v,
`endif
    input  logic [DATA_W-1:0] s,
    output logic              z
);

    assign z = (s == '0);

`ifdef ALU_SEQ_OVF_EN
    op_e op_t;
    logic a_msb, b_msb, s_msb;

    assign op_t  = op_e'(op);
    assign a_msb = a[DATA_W-1];
    assign b_msb = b[DATA_W-1];
    assign s_msb = s[DATA_W-1];

    // ADD overflows when like-signed operands give a differently signed sum;
    // SUB when unlike-signed operands flip the sign of the minuend.
    always_comb begin
        v = 1'b0;
        case (op_t)
            OP_ADD:  v = (a_msb == b_msb) && (s_msb != a_msb);
            OP_SUB:  v = (a_msb != b_msb) && (s_msb != a_msb);
            default: v = 1'b0;
        endcase
    end
`endif

endmodule

// File: rtl/alu_acc_sequencer.sv
// ---------------------------------------------------------------------------
// Module: alu_acc_sequencer
// Purpose: Command stage in front of the 8-bit ALU mux. Accepts op/operand
//          commands over valid/ready, owns the accumulator (ALU operand A)
//          and the carry flag, drives ALU A/B/X/CIN, captures ALU S/COUT and
//          returns a registered result with C/Z (and optional V) flags over
//          a second valid/ready port. The carry flag allows multi-byte
//          add/sub chains. One command every 3 cycles at most; result valid
//          2 cycles after acceptance.
// Configuration macro: ALU_SEQ_OVF_EN (adds res_v signed-overflow output)
// Parameters:
//   DATA_W    operand/accumulator width (fixed at 8)
//   ACC_INIT  accumulator value loaded at reset
// Ports:
//   clk            in   clock, rising edge
//   rst_n          in   synchronous reset, active-low
//   cmd_valid      in   command present
//   cmd_ready      out  command can be accepted (IDLE only, 0 in reset)
//   cmd_op         in   3-bit opcode (see alu_seq_pkg::op_e)
//   cmd_b          in   operand B / LOAD value
//   cmd_use_carry  in   1: ALU CIN = carry flag, 0: CIN = 0
//   alu_a          out  ALU operand A (= accumulator)
//   alu_b          out  ALU operand B (registered)
//   alu_x          out  ALU function select (0..4 only)
//   alu_cin        out  ALU carry/borrow in
//   alu_s          in   ALU result
//   alu_cout       in   ALU carry/borrow out
//   res_valid      out  result present
//   res_ready      in   consumer accepts result
//   res_s          out  result (= new accumulator)
//   res_c          out  carry/borrow flag after op
//   res_z          out  result is zero
//   res_err        out  op was illegal
//   res_v          out  signed overflow (ALU_SEQ_OVF_EN only)
// ---------------------------------------------------------------------------
module alu_acc_sequencer #(
    parameter int                DATA_W   = 8,
    parameter logic [DATA_W-1:0] ACC_INIT = 8'h00
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [DATA_W-1:0] cmd_b,
    input  logic              cmd_use_carry,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [2:0]        alu_x,
    output logic              alu_cin,
    input  logic [DATA_W-1:0] alu_s,
    input  logic              alu_cout,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_s,
    output logic              res_c,
    output logic              res_z,
`ifdef ALU_SEQ_OVF_EN
    output logic              res_v,
`endif
    output logic              res_err
);

    import alu_seq_pkg::*;

    state_e            state, state_nxt;
    op_e               op_q;
    logic [DATA_W-1:0] acc, acc_nxt;
    logic [DATA_W-1:0] b_q;
    logic              c_flag, c_nxt;
    logic              cin_q;
    logic [2:0]        x_q;
    logic              err_nxt;
    logic              z_nxt;
    logic              cmd_fire;

`ifdef ALU_SEQ_OVF_EN
    logic v_nxt;
`endif

    // Ready is qualified with rst_n so no command can slip in while the
    // synchronous reset is being applied.
    assign cmd_ready = (state == IDLE) && rst_n;
    assign cmd_fire  = cmd_valid && cmd_ready;
    assign res_valid = (state == RESP);

    assign alu_a   = acc;
    assign alu_b   = b_q;
    assign alu_x   = x_q;
    assign alu_cin = cin_q;

    // ---------------- FSM next state ----------------
    // NOTE: every combinational output gets a default before the case so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cmd_fire)  state_nxt = EXEC;
            EXEC:    state_nxt = RESP;
            RESP:    if (res_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ---------------- execute: next accumulator / flags ----------------
    always_comb begin
        acc_nxt = acc;
        c_nxt   = c_flag;
        err_nxt = 1'b0;
        case (op_q)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NOT: begin
                // Logic ops clear C because the ALU drives COUT=0 for them.
                acc_nxt = alu_s;
                c_nxt   = alu_cout;
            end
            OP_LOAD: begin
                acc_nxt = b_q;
            end
            OP_CLEAR: begin
                acc_nxt = '0;
                c_nxt   = 1'b0;
            end
            default: begin
                err_nxt = 1'b1;
            end
        endcase
    end

    alu_seq_flags u_flags (
`ifdef ALU_SEQ_OVF_EN
        .a  (acc),
        .b  (b_q),
        .op (3'(op_q)),
        .v  (v_nxt),
`endif
        .s  (acc_nxt),
        .z  (z_nxt)
    );

    // ---------------- registers ----------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            op_q    <= OP_ADD;
            acc     <= ACC_INIT;
            b_q     <= '0;
            c_flag  <= 1'b0;
            cin_q   <= 1'b0;
            x_q     <= 3'd0;
            res_s   <= '0;
            res_c   <= 1'b0;
            res_z   <= 1'b0;
            res_err <= 1'b0;
`ifdef ALU_SEQ_OVF_EN
            res_v   <= 1'b0;
`endif
        end else begin
            state <= state_nxt;

            if (cmd_fire) begin
                op_q  <= op_e'(cmd_op);
                b_q   <= cmd_b;
                cin_q <= cmd_use_carry && c_flag;
                x_q   <= alu_sel(op_e'(cmd_op));
            end

            // ALU inputs have been stable for the whole EXEC cycle, so the
            // ALU result is captured on the edge that leaves EXEC.
            if (state == EXEC) begin
                acc     <= acc_nxt;
                c_flag  <= c_nxt;
                res_s   <= acc_nxt;
                res_c   <= c_nxt;
                res_z   <= z_nxt;
                res_err <= err_nxt;
`ifdef ALU_SEQ_OVF_EN
                res_v   <= v_nxt;
`endif
            end
        end
    end

endmodule

// File: tb/tb_alu_acc_sequencer.sv
// ---------------------------------------------------------------------------
// Testbench: tb_alu_acc_sequencer
// Purpose: Directed self-checking bench for alu_acc_sequencer. Includes a
//          behavioural model of the 8-bit ALU mux driven by the DUT's ALU
//          port; expected results are hand-computed constants.
// Configuration macro: ALU_SEQ_OVF_EN (also checks res_v)
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_alu_acc_sequencer;
    import alu_seq_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [7:0] cmd_b;
    logic       cmd_use_carry;
    logic [7:0] alu_a, alu_b, alu_s;
    logic [2:0] alu_x;
    logic       alu_cin, alu_cout;
    logic       res_valid, res_ready;
    logic [7:0] res_s;
    logic       res_c, res_z, res_err;
`ifdef ALU_SEQ_OVF_EN
    logic       res_v;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    // Values sampled by run_cmd
    logic [7:0] r_s, r_b;
    logic [2:0] r_x;
    logic       r_c, r_z, r_err, r_cin, r_v;
    int         r_lat;

    always #5 clk = ~clk;

    alu_acc_sequencer #(.DATA_W(8), .ACC_INIT(8'h00)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_op        (cmd_op),
        .cmd_b         (cmd_b),
        .cmd_use_carry (cmd_use_carry),
        .alu_a         (alu_a),
        .alu_b         (alu_b),
        .alu_x         (alu_x),
        .alu_cin       (alu_cin),
        .alu_s         (alu_s),
        .alu_cout      (alu_cout),
        .res_valid     (res_valid),
        .res_ready     (res_ready),
        .res_s         (res_s),
        .res_c         (res_c),
        .res_z         (res_z),
`ifdef ALU_SEQ_OVF_EN
        .res_v         (res_v),
`endif
        .res_err       (res_err)
    );

    // Behavioural 8-bit ALU mux
    always_comb begin
        alu_s    = 8'h00;
        alu_cout = 1'b0;
        case (alu_x)
            3'd0: {alu_cout, alu_s} = {1'b0, alu_a} + {1'b0, alu_b} + {8'h00, alu_cin};
            3'd1: begin
                alu_s    = alu_a - alu_b - {7'h00, alu_cin};
                alu_cout = ({1'b0, alu_a} < ({1'b0, alu_b} + {8'h00, alu_cin}));
            end
            3'd2: alu_s = alu_a & alu_b;
            3'd3: alu_s = alu_a | alu_b;
            3'd4: alu_s = ~alu_a;
            default: alu_s = 8'h00;
        endcase
    end

    // Issue one command, sample the ALU drive during EXEC, wait for the
    // result and sample it; completes the handshake when res_ready is high.
    task automatic run_cmd(input logic [2:0] op, input logic [7:0] b, input logic uc);
        int n;
        @(negedge clk);
        cmd_op = op; cmd_b = b; cmd_use_carry = uc; cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 16) begin @(negedge clk); n++; end
        if (!cmd_ready) begin
            n_chk++; n_fail++;
            $display("FAIL accept_timeout: cmd_ready=%b required 1", cmd_ready);
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        r_x = alu_x; r_b = alu_b; r_cin = alu_cin;
        r_lat = 1;
        while (!res_valid && r_lat < 16) begin @(posedge clk); #1; r_lat++; end
        r_s = res_s; r_c = res_c; r_z = res_z; r_err = res_err;
`ifdef ALU_SEQ_OVF_EN
        r_v = res_v;
`else
        r_v = 1'b0;
`endif
        if (res_ready) begin @(posedge clk); #1; end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_b = 8'h00;
        cmd_use_carry = 1'b0; res_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_chk++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL rst_cmd_ready: got %b required 0", cmd_ready); end
        n_chk++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL rst_res_valid: got %b required 0", res_valid); end
        n_chk++; if ({res_s, res_c, res_z, res_err} !== 11'h000) begin n_fail++;
            $display("FAIL rst_res: s=%h c=%b z=%b err=%b required 00 0 0 0", res_s, res_c, res_z, res_err); end
        n_chk++; if ({alu_a, alu_b, alu_x, alu_cin} !== 20'h00000) begin n_fail++;
            $display("FAIL rst_alu: a=%h b=%h x=%0d cin=%b required 00 00 0 0", alu_a, alu_b, alu_x, alu_cin); end
`ifdef ALU_SEQ_OVF_EN
        n_chk++; if (res_v !== 1'b0) begin n_fail++; $display("FAIL rst_v: got %b required 0", res_v); end
`endif
        rst_n = 1'b1;
        #1;
        n_chk++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL post_rst_ready: got %b required 1", cmd_ready); end
    endtask

    task automatic test_add_overflow;
        run_cmd(OP_LOAD, 8'h7F, 1'b0);
        n_chk++; if (r_s !== 8'h7F) begin n_fail++; $display("FAIL load7f_s: got %h required 7f", r_s); end
        n_chk++; if (r_x !== 3'd0) begin n_fail++; $display("FAIL load_x: got %0d required 0", r_x); end
        run_cmd(OP_ADD, 8'h01, 1'b0);
        n_chk++; if (r_lat !== 2) begin n_fail++; $display("FAIL add_latency: got %0d required 2", r_lat); end
        n_chk++; if (r_b !== 8'h01) begin n_fail++; $display("FAIL add_alu_b: got %h required 01", r_b); end
        n_chk++; if ({r_s, r_c, r_z, r_err} !== {8'h80, 3'b000}) begin n_fail++;
            $display("FAIL add_res: s=%h c=%b z=%b err=%b required 80 0 0 0", r_s, r_c, r_z, r_err); end
`ifdef ALU_SEQ_OVF_EN
        n_chk++; if (r_v !== 1'b1) begin n_fail++; $display("FAIL add_v: got %b required 1", r_v); end
`endif
        n_chk++; if (alu_a !== 8'h80) begin n_fail++; $display("FAIL add_acc: got %h required 80", alu_a); end
    endtask

    task automatic test_sub_carry;
        run_cmd(OP_CLEAR, 8'h55, 1'b0);
        n_chk++; if ({r_s, r_c, r_z} !== {8'h00, 2'b01}) begin n_fail++;
            $display("FAIL clear_res: s=%h c=%b z=%b required 00 0 1", r_s, r_c, r_z); end
        run_cmd(OP_SUB, 8'h01, 1'b0);
        n_chk++; if (r_x !== 3'd1) begin n_fail++; $display("FAIL sub_x: got %0d required 1", r_x); end
        n_chk++; if ({r_s, r_c, r_z} !== {8'hFF, 2'b10}) begin n_fail++;
            $display("FAIL sub_res: s=%h c=%b z=%b required ff 1 0", r_s, r_c, r_z); end
`ifdef ALU_SEQ_OVF_EN
        n_chk++; if (r_v !== 1'b0) begin n_fail++; $display("FAIL sub_v: got %b required 0", r_v); end
`endif
        run_cmd(OP_ADD, 8'h00, 1'b1);
        n_chk++; if (r_cin !== 1'b1) begin n_fail++; $display("FAIL addc_cin: got %b required 1", r_cin); end
        n_chk++; if ({r_s, r_c, r_z} !== {8'h00, 2'b11}) begin n_fail++;
            $display("FAIL addc_res: s=%h c=%b z=%b required 00 1 1", r_s, r_c, r_z); end
    endtask

    task automatic test_chain;
        run_cmd(OP_LOAD, 8'hFF, 1'b0);
        n_chk++; if ({r_s, r_c} !== {8'hFF, 1'b1}) begin n_fail++;
            $display("FAIL chain_load_ff: s=%h c=%b required ff 1", r_s, r_c); end
        run_cmd(OP_ADD, 8'h01, 1'b0);
        n_chk++; if ({r_s, r_c, r_z} !== {8'h00, 2'b11}) begin n_fail++;
            $display("FAIL chain_add_lo: s=%h c=%b z=%b required 00 1 1", r_s, r_c, r_z); end
        run_cmd(OP_LOAD, 8'h00, 1'b0);
        n_chk++; if ({r_s, r_c} !== {8'h00, 1'b1}) begin n_fail++;
            $display("FAIL chain_load_00: s=%h c=%b required 00 1", r_s, r_c); end
        run_cmd(OP_ADD, 8'h00, 1'b1);
        n_chk++; if ({r_s, r_c, r_z} !== {8'h01, 2'b00}) begin n_fail++;
            $display("FAIL chain_add_hi: s=%h c=%b z=%b required 01 0 0", r_s, r_c, r_z); end
    endtask

    task automatic test_backpressure;
        int n;
        run_cmd(OP_LOAD, 8'hA5, 1'b0);
        res_ready = 1'b0;
        @(negedge clk);
        cmd_op = OP_AND; cmd_b = 8'h0F; cmd_use_carry = 1'b0; cmd_valid = 1'b1;
        @(posedge clk); #1;
        n_chk++; if (alu_x !== 3'd2) begin n_fail++; $display("FAIL bp_and_x: got %0d required 2", alu_x); end
        // A second command stays offered while the first is stalled
        cmd_op = OP_OR; cmd_b = 8'hF0;
        n = 0;
        while (!res_valid && n < 16) begin @(posedge clk); #1; n++; end
        n_chk++; if (n !== 1) begin n_fail++; $display("FAIL bp_latency: edges=%0d required 1", n); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_chk++; if ({res_valid, cmd_ready, res_s, res_c, res_z} !== {2'b10, 8'h05, 2'b00}) begin n_fail++;
                $display("FAIL bp_hold%0d: valid=%b ready=%b s=%h c=%b z=%b required 1 0 05 0 0",
                         i, res_valid, cmd_ready, res_s, res_c, res_z); end
        end
        res_ready = 1'b1;
        @(posedge clk); #1;
        n_chk++; if ({res_valid, cmd_ready} !== 2'b01) begin n_fail++;
            $display("FAIL bp_release: valid=%b ready=%b required 0 1", res_valid, cmd_ready); end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        n_chk++; if ({cmd_ready, alu_x} !== {1'b0, 3'd3}) begin n_fail++;
            $display("FAIL bp_next_accept: ready=%b x=%0d required 0 3", cmd_ready, alu_x); end
        @(posedge clk); #1;
        n_chk++; if ({res_valid, res_s, res_c} !== {1'b1, 8'hF5, 1'b0}) begin n_fail++;
            $display("FAIL bp_or_res: valid=%b s=%h c=%b required 1 f5 0", res_valid, res_s, res_c); end
        @(posedge clk); #1;
    endtask

    task automatic test_illegal_and_reset;
        run_cmd(OP_CLEAR, 8'h00, 1'b0);
        run_cmd(OP_SUB, 8'h01, 1'b0);
        run_cmd(OP_LOAD, 8'h3C, 1'b0);
        n_chk++; if ({r_s, r_c, r_err} !== {8'h3C, 2'b10}) begin n_fail++;
            $display("FAIL ill_pre_load: s=%h c=%b err=%b required 3c 1 0", r_s, r_c, r_err); end
        run_cmd(OP_ILL, 8'h99, 1'b1);
        n_chk++; if ({r_s, r_c, r_z, r_err} !== {8'h3C, 3'b101}) begin n_fail++;
            $display("FAIL ill_res: s=%h c=%b z=%b err=%b required 3c 1 0 1", r_s, r_c, r_z, r_err); end
        n_chk++; if (r_x !== 3'd0) begin n_fail++; $display("FAIL ill_x: got %0d required 0", r_x); end
        // Reset asserted while an ADD is in EXEC
        @(negedge clk);
        cmd_op = OP_ADD; cmd_b = 8'h01; cmd_use_carry = 1'b0; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        n_chk++; if ({res_valid, cmd_ready, alu_a, res_err} !== {2'b00, 8'h00, 1'b0}) begin n_fail++;
            $display("FAIL rst_exec: valid=%b ready=%b acc=%h err=%b required 0 0 00 0",
                     res_valid, cmd_ready, alu_a, res_err); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_chk++; if ({res_valid, cmd_ready} !== 2'b01) begin n_fail++;
            $display("FAIL rst_exec_after: valid=%b ready=%b required 0 1", res_valid, cmd_ready); end
    endtask

    initial begin
        test_reset();
        test_add_overflow();
        test_sub_carry();
        test_chain();
        test_backpressure();
        test_illegal_and_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
